// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_xcvr transceiver.
// Included first; the other rtl files import it.
package uart_pkg;

    typedef enum logic [1:0] {NONE, EVEN, ODD} parity_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    function automatic int frame_len(input int data_w,
                                     input int parity,
                                     input int stop_bits);
        return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Receiver: 2-flop synchroniser, sampling FSM, parity/framing flags.
// Start is checked mid-bit so short glitches are rejected as false starts.
module uart_rx_core import uart_pkg::*; #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              line_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              par_err_o,
    output logic              frame_err_o,
    output logic              busy_o
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam bit HAS_P = PARITY != int'(NONE);
    localparam bit ODD_P = PARITY == int'(ODD);

    rx_state_e         state_q, state_d;
    logic [1:0]        sync_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
    logic              perr_q, perr_d, valid_q, valid_d;
    logic              pe_q, pe_d, fe_q, fe_d;
    logic              line, smp;

    assign line = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        valid_d = 1'b0;
        data_d  = data_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        if (state_q == RX_START)
            smp = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
        else
            smp = cnt_q == CW'(CLKS_PER_BIT - 1);
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!line) state_d = RX_START;
            end
            RX_START: if (smp) begin
                cnt_d   = '0;
                state_d = line ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (smp) begin
                cnt_d = '0;
                sh_d  = {line, sh_q[DATA_W-1:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 4'(DATA_W - 1))
                    state_d = HAS_P ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (smp) begin
                cnt_d   = '0;
                perr_d  = line ^ (^sh_q) ^ ODD_P;
                state_d = RX_STOP;
            end
            RX_STOP: if (smp) begin
                // Back to idle at once: a new start may follow the stop sample
                state_d = RX_IDLE;
                valid_d = 1'b1;
                data_d  = sh_q;
                fe_d    = ~line;
                pe_d    = HAS_P & perr_q;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], line_i};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign par_err_o   = pe_q;
    assign frame_err_o = fe_q;
    assign busy_o      = state_q != RX_IDLE;

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: transmitter FSM, loopback mux and receiver core.
// TxD is registered so reset and state changes never glitch the line.
module uart_xcvr import uart_pkg::*; #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Loop,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    output logic              TxReady,
    output logic              TxD,
    input  logic              RxD,
    output logic [DATA_W-1:0] RxData,
    output logic              RxValid,
    output logic              RxParityErr,
    output logic              RxFrameErr,
    output logic              RxBusy
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int FL    = frame_len(DATA_W, PARITY, STOP_BITS);
    localparam bit HAS_P = PARITY != int'(NONE);
    localparam bit ODD_P = PARITY == int'(ODD);

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d, tx_q, tx_d;
    logic              last_cyc, rx_line;

    // bit_q indexes the frame: 0 = start, 1..DATA_W = data, then parity/stop
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_d    = par_q;
        last_cyc = cnt_q == CW'(CLKS_PER_BIT - 1);
        if (state_q == TX_IDLE) begin
            bit_d = '0;
            if (TxValid) begin
                state_d = TX_START;
                sh_d    = TxData;
                par_d   = (^TxData) ^ ODD_P;
            end
        end else if (!last_cyc) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            bit_d = bit_q + 1'b1;
            unique case (state_q)
                TX_START: state_d = TX_DATA;
                TX_DATA: begin
                    sh_d = sh_q >> 1;
                    if (bit_q == 4'(DATA_W))
                        state_d = HAS_P ? TX_PARITY : TX_STOP;
                end
                TX_PARITY: state_d = TX_STOP;
                TX_STOP: if (bit_q == 4'(FL - 1)) state_d = TX_IDLE;
                default: state_d = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = sh_d[0];
            TX_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign TxReady = state_q == TX_IDLE;
    assign TxD     = tx_q | Loop;
    assign rx_line = Loop ? tx_q : RxD;

    uart_rx_core #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PARITY      (PARITY)
    ) u_rx (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .line_i     (rx_line),
        .data_o     (RxData),
        .valid_o    (RxValid),
        .par_err_o  (RxParityErr),
        .frame_err_o(RxFrameErr),
        .busy_o     (RxBusy)
    );

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: four configurations, one linear sequence.
// Received words are logged per instance and checked after each step.
module tb_uart_xcvr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc++;

    // u0: 8N1, loopback or bench-driven RxD
    logic       loop0, txv0, txr0, txd0, rxd0, rxd0_drv, wire_lb;
    logic       rxv0, pe0, fe0, busy0;
    logic [7:0] txdat0, rxdat0;
    assign rxd0 = wire_lb ? txd0 : rxd0_drv;

    uart_xcvr u0 (
        .Clk(clk), .Rst(rst), .Loop(loop0),
        .TxData(txdat0), .TxValid(txv0), .TxReady(txr0), .TxD(txd0),
        .RxD(rxd0), .RxData(rxdat0), .RxValid(rxv0),
        .RxParityErr(pe0), .RxFrameErr(fe0), .RxBusy(busy0)
    );

    // u1 even parity, u2 odd parity; both listen on rxd12
    logic       rxd12;
    logic       txr1, txd1, rxv1, pe1, fe1, busy1;
    logic       txr2, txd2, rxv2, pe2, fe2, busy2;
    logic [7:0] rxdat1, rxdat2;

    uart_xcvr #(.PARITY(1)) u1 (
        .Clk(clk), .Rst(rst), .Loop(1'b0),
        .TxData(8'h00), .TxValid(1'b0), .TxReady(txr1), .TxD(txd1),
        .RxD(rxd12), .RxData(rxdat1), .RxValid(rxv1),
        .RxParityErr(pe1), .RxFrameErr(fe1), .RxBusy(busy1)
    );

    uart_xcvr #(.PARITY(2)) u2 (
        .Clk(clk), .Rst(rst), .Loop(1'b0),
        .TxData(8'h00), .TxValid(1'b0), .TxReady(txr2), .TxD(txd2),
        .RxD(rxd12), .RxData(rxdat2), .RxValid(rxv2),
        .RxParityErr(pe2), .RxFrameErr(fe2), .RxBusy(busy2)
    );

    // u3: 9 data bits, 2 stop bits, loopback
    logic       txv3, txr3, txd3, rxv3, pe3, fe3, busy3;
    logic [8:0] txdat3, rxdat3;

    uart_xcvr #(.DATA_W(9), .STOP_BITS(2)) u3 (
        .Clk(clk), .Rst(rst), .Loop(1'b1),
        .TxData(txdat3), .TxValid(txv3), .TxReady(txr3), .TxD(txd3),
        .RxD(1'b1), .RxData(rxdat3), .RxValid(rxv3),
        .RxParityErr(pe3), .RxFrameErr(fe3), .RxBusy(busy3)
    );

    // log record: {parity_err, frame_err, data[8:0]}
    logic [10:0] rec0[16], rec1[16], rec2[16], rec3[16];
    int n0 = 0, n1 = 0, n2 = 0, n3 = 0;

    always @(negedge clk) begin
        if (rxv0) begin rec0[n0 & 15] = {pe0, fe0, 1'b0, rxdat0}; n0++; end
        if (rxv1) begin rec1[n1 & 15] = {pe1, fe1, 1'b0, rxdat1}; n1++; end
        if (rxv2) begin rec2[n2 & 15] = {pe2, fe2, 1'b0, rxdat2}; n2++; end
        if (rxv3) begin rec3[n3 & 15] = {pe3, fe3, rxdat3}; n3++; end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv_bit(input int sel, input logic b, input int n);
        if (sel == 0) rxd0_drv = b;
        else rxd12 = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d,
                              input int nb, input bit hp,
                              input logic pb, input logic sb);
        drv_bit(sel, 1'b0, 16);
        for (int i = 0; i < nb; i++) drv_bit(sel, d[i], 16);
        if (hp) drv_bit(sel, pb, 16);
        drv_bit(sel, sb, 16);
        drv_bit(sel, 1'b1, 32);
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? txr0 : txr3;
    endfunction

    task automatic b2b(input int sel, input logic [8:0] w0,
                       input logic [8:0] w1, input logic [8:0] w2,
                       input int f, input string tag);
        logic [8:0] w[3];
        int t[3];
        int k;
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int i = 0; i < 3; i++) begin
            if (sel == 0) begin txdat0 = w[i][7:0]; txv0 = 1'b1; end
            else begin txdat3 = w[i]; txv3 = 1'b1; end
            k = 0;
            while (!rdy(sel) && k < 400) begin @(negedge clk); k++; end
            t[i] = cyc;
            @(negedge clk);
        end
        if (sel == 0) txv0 = 1'b0;
        else txv3 = 1'b0;
        chk({tag, "_gap01"}, 32'(t[1] - t[0]), 32'(f + 1));
        chk({tag, "_gap12"}, 32'(t[2] - t[1]), 32'(f + 1));
    endtask

    initial begin
        int base, base2, k;
        logic seen;
        rst = 1'b1; loop0 = 1'b0; wire_lb = 1'b0;
        txv0 = 1'b0; txdat0 = '0; rxd0_drv = 1'b1; rxd12 = 1'b1;
        txv3 = 1'b0; txdat3 = '0;
        #2;
        chk("rst_txd",   32'(txd0),   32'h1);
        chk("rst_txrdy", 32'(txr0),   32'h1);
        chk("rst_rxv",   32'(rxv0),   32'h0);
        chk("rst_rxdat", 32'(rxdat0), 32'h0);
        chk("rst_pe",    32'(pe0),    32'h0);
        chk("rst_fe",    32'(fe0),    32'h0);
        chk("rst_busy",  32'(busy0),  32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // loopback 0xA5, 8N1: TxReady low for 160 cycles
        loop0 = 1'b1; base = n0;
        txdat0 = 8'hA5; txv0 = 1'b1;
        @(negedge clk);
        txv0 = 1'b0;
        chk("lb_rdy_drop", 32'(txr0), 32'h0);
        chk("lb_txd_held", 32'(txd0), 32'h1);
        k = 0;
        while (!txr0 && k < 400) begin k++; @(negedge clk); end
        chk("lb_busy_len", 32'(k), 32'd160);
        repeat (30) @(negedge clk);
        chk("lb_count", 32'(n0 - base), 32'd1);
        chk("lb_rec", 32'(rec0[base & 15]), 32'h0A5);

        // 0x07 with parity bit 0: wrong for even, right for odd
        base = n1; base2 = n2;
        send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1'b1);
        chk("even_count", 32'(n1 - base), 32'd1);
        chk("even_rec", 32'(rec1[base & 15]), 32'h407);
        chk("odd_count", 32'(n2 - base2), 32'd1);
        chk("odd_rec", 32'(rec2[base2 & 15]), 32'h007);

        // stop bit low on 0x3C, then a clean 0x55
        loop0 = 1'b0; base = n0;
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b1);
        chk("fe_count", 32'(n0 - base), 32'd2);
        chk("fe_rec", 32'(rec0[base & 15]), 32'h23C);
        chk("fe_next", 32'(rec0[(base + 1) & 15]), 32'h055);

        // 4-cycle glitch is a false start
        base = n0; seen = 1'b0;
        rxd0_drv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy0) seen = 1'b1;
        end
        rxd0_drv = 1'b1;
        k = 0;
        while (busy0 && k < 10) begin @(negedge clk); k++; end
        chk("fs_busy_seen", 32'(seen), 32'h1);
        chk("fs_busy_clear", 32'(busy0), 32'h0);
        repeat (20) @(negedge clk);
        chk("fs_no_valid", 32'(n0 - base), 32'd0);

        // back-to-back with TxValid held, 8N1 and 9-bit/2-stop
        loop0 = 1'b1; base = n0;
        b2b(0, 9'h001, 9'h080, 9'h0FF, 160, "b2b8");
        repeat (250) @(negedge clk);
        chk("b2b8_count", 32'(n0 - base), 32'd3);
        chk("b2b8_w0", 32'(rec0[base & 15]), 32'h001);
        chk("b2b8_w1", 32'(rec0[(base + 1) & 15]), 32'h080);
        chk("b2b8_w2", 32'(rec0[(base + 2) & 15]), 32'h0FF);
        base = n3;
        b2b(3, 9'h001, 9'h080, 9'h1FF, 192, "b2b9");
        repeat (250) @(negedge clk);
        chk("b2b9_count", 32'(n3 - base), 32'd3);
        chk("b2b9_w0", 32'(rec3[base & 15]), 32'h001);
        chk("b2b9_w1", 32'(rec3[(base + 1) & 15]), 32'h080);
        chk("b2b9_w2", 32'(rec3[(base + 2) & 15]), 32'h1FF);

        // reset mid data bit 2 of 0x5A, external wire loop
        loop0 = 1'b0; wire_lb = 1'b1;
        txdat0 = 8'h5A; txv0 = 1'b1;
        @(negedge clk);
        txv0 = 1'b0;
        repeat (56) @(negedge clk);
        chk("mr_tx_busy", 32'(txr0), 32'h0);
        chk("mr_txd_low", 32'(txd0), 32'h0);
        chk("mr_rx_busy", 32'(busy0), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mr_txd",   32'(txd0),   32'h1);
        chk("mr_txrdy", 32'(txr0),   32'h1);
        chk("mr_busy",  32'(busy0),  32'h0);
        chk("mr_rxv",   32'(rxv0),   32'h0);
        chk("mr_rxdat", 32'(rxdat0), 32'h0);
        chk("mr_flags", 32'({pe0, fe0}), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        base = n0;
        txdat0 = 8'h3A; txv0 = 1'b1;
        @(negedge clk);
        txv0 = 1'b0;
        k = 0;
        while (!txr0 && k < 400) begin k++; @(negedge clk); end
        chk("pr_busy_len", 32'(k), 32'd160);
        repeat (30) @(negedge clk);
        chk("pr_count", 32'(n0 - base), 32'd1);
        chk("pr_rec", 32'(rec0[base & 15]), 32'h03A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised full-duplex UART transceiver: one transmitter and one receiver sharing a clock, with configurable data width, bit period, parity and stop bits, plus an internal loopback mode. It replaces separately instantiated TX and RX UARTs wired point-to-point. It adds a ready/valid transmit handshake, parity and framing error detection, and false-start rejection.

## Interface
- DATA_W, 8, data bits per frame, legal 5..9
- CLKS_PER_BIT, 16, Clk cycles per bit, even, >= 4
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- Loop  in  1  1 = receiver fed from internal TX line and TxD forced high; 0 = receiver fed from RxD
- TxData  in  DATA_W  word to send, sampled at handshake
- TxValid  in  1  transmit request
- TxReady  out  1  transmitter idle, accepts TxData
- TxD  out  1  serial output, idle high
- RxD  in  1  serial input, asynchronous
- RxData  out  DATA_W  last received word, held until next RxValid
- RxValid  out  1  one-cycle pulse, new word on RxData
- RxParityErr  out  1  parity mismatch, qualified by RxValid
- RxFrameErr  out  1  stop bit sampled low, qualified by RxValid
- RxBusy  out  1  receiver not in IDLE

## Operation
- Frame: start (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- P = (PARITY != 0) ? 1 : 0.
- Even parity bit = XOR of data. Odd parity bit = its inverse.
- TX FSM: IDLE → START → DATA → PARITY (skipped if PARITY = 0) → STOP → IDLE.
  - TxReady = 1 only in IDLE.
  - Handshake (TxValid & TxReady at an edge) latches TxData into a shift register.
  - Every bit is held exactly CLKS_PER_BIT cycles. A bit counter tracks data and stop bits.
- RX:
  - RxD, or the internal TX line when Loop = 1, passes through a 2-flop synchroniser reset to 1.
  - RX FSM: IDLE → START → DATA → PARITY (skipped if PARITY = 0) → STOP → IDLE.
  - IDLE → START when the synchronised line is 0.
  - Start is sampled at CLKS_PER_BIT/2 − 1 cycles after entry. If it reads 1, this is a false start: return to IDLE with no RxValid and no flags.
  - Each later bit is sampled CLKS_PER_BIT cycles after the previous sample.
  - Only the first stop bit is checked.
  - After the stop sample, go to IDLE immediately, so a new start can be detected from the next cycle.
- On RxValid, RxData is updated even if an error is flagged. RxParityErr is 0 whenever PARITY = 0.
- A Loop change while TX or RX is busy is a usage error. Neither FSM may hang: each returns to IDLE within one frame.

## Timing
- Reset values: TxD = 1, TxReady = 1, RxData = 0, RxValid = 0, RxParityErr = 0, RxFrameErr = 0, RxBusy = 0, both FSMs IDLE, synchroniser = 1.
- Rst asserted mid-frame aborts both FSMs asynchronously. TxD goes high with no glitch to 0.
- TX:
  - Handshake at edge k: TxD = 0 from edge k+1.
  - TxReady deasserts from edge k+1.
  - TxReady reasserts after F = CLKS_PER_BIT·(1+DATA_W+P+STOP_BITS) cycles.
  - With TxValid held high, the next start bit follows after exactly 1 IDLE cycle.
- RX:
  - Let s be the cycle the FSM enters START. Sample n (n = 0 for start) occurs at s + CLKS_PER_BIT/2 − 1 + n·CLKS_PER_BIT.
  - RxValid is asserted in the cycle after the stop sample.
  - In loopback, RxValid occurs exactly once per frame, before the following frame's start sample.

## Structure
- Package uart_pkg holds:
  - parity_e (NONE, EVEN, ODD)
  - tx_state_e and rx_state_e
  - function frame_len(DATA_W, PARITY, STOP_BITS) returning bits per frame.
- One sub-module, uart_rx_core: synchroniser, RX FSM, and error flags.
- TX FSM and the loopback mux live in uart_xcvr.

## Test plan
- DATA_W = 8, CLKS_PER_BIT = 16, PARITY = 0, Loop = 1, send 0xA5 → TxReady low for 160 cycles; RxValid once with RxData = 0xA5, no error flags.
- PARITY = 1, send 0x07 via RxD model with wrong parity bit 0 → RxData = 0x07, RxParityErr = 1. Repeat with PARITY = 2 and correct bit 0 → no error.
- RxD model drives stop bit 0 on 0x3C → RxValid, RxData = 0x3C, RxFrameErr = 1. A following good frame 0x55 is received cleanly.
- RxD pulsed low for CLKS_PER_BIT/4 cycles → no RxValid, RxBusy returns to 0 within CLKS_PER_BIT/2 + 2 cycles.
- TxValid held high, Loop = 1, sequence 0x01, 0x80, 0xFF, DATA_W = 9 and STOP_BITS = 2 variant → consecutive start bits F + 1 cycles apart; all words received in order.
- Rst asserted mid-data-bit of TX and RX → all outputs at reset values immediately. First frame after release is transmitted and received correctly.
